// File: rtl/ques1_pkg.sv
// Shared function-index constants and result vector type for the ques1 logic banks.
package ques1_pkg;

  localparam int unsigned FN_AND   = 0;
  localparam int unsigned FN_OR    = 1;
  localparam int unsigned FN_NOT_A = 2;
  localparam int unsigned FN_NOT_B = 3;
  localparam int unsigned FN_NAND  = 4;
  localparam int unsigned FN_NOR   = 5;
  localparam int unsigned FN_XOR   = 6;
  localparam int unsigned FN_XNOR  = 7;
  localparam int unsigned FN_COUNT = 8;

  localparam int STYLE_GATE     = 0;
  localparam int STYLE_DATAFLOW = 1;
  localparam int STYLE_PROC     = 2;

  typedef logic [FN_COUNT-1:0] res_t;

endpackage

// File: rtl/ques1_logic_bank.sv
// Combinational eight-function bank over two bits; STYLE selects gate, dataflow or procedural coding.
// Zero latency, no state, no backpressure.
module ques1_logic_bank
  import ques1_pkg::*;
#(
  parameter int STYLE = STYLE_GATE
) (
  input  logic a_i,
  input  logic b_i,
  output res_t res_o
);

  if (STYLE == STYLE_GATE) begin : g_gate
    logic w_and, w_or, w_na, w_nb, w_nand, w_nor, w_xor, w_xnor;
    and  u_and  (w_and,  a_i, b_i);
    or   u_or   (w_or,   a_i, b_i);
    not  u_na   (w_na,   a_i);
    not  u_nb   (w_nb,   b_i);
    nand u_nand (w_nand, a_i, b_i);
    nor  u_nor  (w_nor,  a_i, b_i);
    xor  u_xor  (w_xor,  a_i, b_i);
    xnor u_xnor (w_xnor, a_i, b_i);
    assign res_o[FN_AND]   = w_and;
    assign res_o[FN_OR]    = w_or;
    assign res_o[FN_NOT_A] = w_na;
    assign res_o[FN_NOT_B] = w_nb;
    assign res_o[FN_NAND]  = w_nand;
    assign res_o[FN_NOR]   = w_nor;
    assign res_o[FN_XOR]   = w_xor;
    assign res_o[FN_XNOR]  = w_xnor;
  end else if (STYLE == STYLE_DATAFLOW) begin : g_dataflow
    assign res_o[FN_AND]   = a_i & b_i;
    assign res_o[FN_OR]    = a_i | b_i;
    assign res_o[FN_NOT_A] = ~a_i;
    assign res_o[FN_NOT_B] = ~b_i;
    assign res_o[FN_NAND]  = ~(a_i & b_i);
    assign res_o[FN_NOR]   = ~(a_i | b_i);
    assign res_o[FN_XOR]   = a_i ^ b_i;
    assign res_o[FN_XNOR]  = ~(a_i ^ b_i);
  end else begin : g_proc
    always_comb begin
      res_o          = '0;
      res_o[FN_AND]  = a_i & b_i;
      res_o[FN_OR]   = a_i | b_i;
      res_o[FN_NOT_A] = !a_i;
      res_o[FN_NOT_B] = !b_i;
      res_o[FN_NAND] = !(a_i && b_i);
      res_o[FN_NOR]  = !(a_i || b_i);
      res_o[FN_XOR]  = a_i != b_i;
      res_o[FN_XNOR] = a_i == b_i;
    end
  end

endmodule

// File: rtl/ques1.sv
// Three redundant registered logic banks over in1/in2; 1-cycle latency, accepts a pair every cycle, no backpressure.
// Define QUES1_MISMATCH_CHK_EN to add the sticky cross-bank mismatch flag.
module ques1
  import ques1_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in1,
  input  logic in2,
  output logic outand,
  output logic outor,
  output logic notin1,
  output logic notin2,
  output logic outnand,
  output logic outnor,
  output logic outxor,
  output logic outxnor,
  output logic outand1,
  output logic outor1,
  output logic notin11,
  output logic notin12,
  output logic outnand1,
  output logic outnor1,
  output logic outxor1,
  output logic outxnor1,
  output logic outand2,
  output logic outor2,
  output logic notin21,
  output logic notin22,
  output logic outnand2,
  output logic outnor2,
  output logic outxor2,
  output logic outxnor2
`ifdef QUES1_MISMATCH_CHK_EN
  ,
  output logic mismatch
`endif
);

  res_t res0_d, res1_d, res2_d;
  res_t res0_q, res1_q, res2_q;

  ques1_logic_bank #(.STYLE(STYLE_GATE))     u_bank0 (.a_i(in1), .b_i(in2), .res_o(res0_d));
  ques1_logic_bank #(.STYLE(STYLE_DATAFLOW)) u_bank1 (.a_i(in1), .b_i(in2), .res_o(res1_d));
  ques1_logic_bank #(.STYLE(STYLE_PROC))     u_bank2 (.a_i(in1), .b_i(in2), .res_o(res2_d));

  // Reset clears inverting functions too, so every output reads 0 during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      res0_q <= '0;
      res1_q <= '0;
      res2_q <= '0;
    end else begin
      res0_q <= res0_d;
      res1_q <= res1_d;
      res2_q <= res2_d;
    end
  end

`ifdef QUES1_MISMATCH_CHK_EN
  logic mismatch_d, mismatch_q;

  assign mismatch_d = mismatch_q | (res1_q != res0_q) | (res2_q != res0_q);

  always_ff @(posedge clk) begin
    if (rst) mismatch_q <= 1'b0;
    else     mismatch_q <= mismatch_d;
  end

  assign mismatch = mismatch_q;
`endif

  assign outand   = res0_q[FN_AND];
  assign outor    = res0_q[FN_OR];
  assign notin1   = res0_q[FN_NOT_A];
  assign notin2   = res0_q[FN_NOT_B];
  assign outnand  = res0_q[FN_NAND];
  assign outnor   = res0_q[FN_NOR];
  assign outxor   = res0_q[FN_XOR];
  assign outxnor  = res0_q[FN_XNOR];

  assign outand1  = res1_q[FN_AND];
  assign outor1   = res1_q[FN_OR];
  assign notin11  = res1_q[FN_NOT_A];
  assign notin12  = res1_q[FN_NOT_B];
  assign outnand1 = res1_q[FN_NAND];
  assign outnor1  = res1_q[FN_NOR];
  assign outxor1  = res1_q[FN_XOR];
  assign outxnor1 = res1_q[FN_XNOR];

  assign outand2  = res2_q[FN_AND];
  assign outor2   = res2_q[FN_OR];
  assign notin21  = res2_q[FN_NOT_A];
  assign notin22  = res2_q[FN_NOT_B];
  assign outnand2 = res2_q[FN_NAND];
  assign outnor2  = res2_q[FN_NOR];
  assign outxor2  = res2_q[FN_XOR];
  assign outxnor2 = res2_q[FN_XNOR];

endmodule

// File: tb/tb_ques1.sv
// Self-checking bench for ques1: directed reset/sweep/glitch steps then random pairs against a truth-table model.
module tb_ques1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in1 = 1'b1;
  logic in2 = 1'b1;

  logic outand, outor, notin1, notin2, outnand, outnor, outxor, outxnor;
  logic outand1, outor1, notin11, notin12, outnand1, outnor1, outxor1, outxnor1;
  logic outand2, outor2, notin21, notin22, outnand2, outnor2, outxor2, outxnor2;
`ifdef QUES1_MISMATCH_CHK_EN
  logic mismatch;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ques1 dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2),
    .outand(outand), .outor(outor), .notin1(notin1), .notin2(notin2),
    .outnand(outnand), .outnor(outnor), .outxor(outxor), .outxnor(outxnor),
    .outand1(outand1), .outor1(outor1), .notin11(notin11), .notin12(notin12),
    .outnand1(outnand1), .outnor1(outnor1), .outxor1(outxor1), .outxnor1(outxnor1),
    .outand2(outand2), .outor2(outor2), .notin21(notin21), .notin22(notin22),
    .outnand2(outnand2), .outnor2(outnor2), .outxor2(outxor2), .outxnor2(outxnor2)
`ifdef QUES1_MISMATCH_CHK_EN
    , .mismatch(mismatch)
`endif
  );

  // Observed banks, bit order: AND OR NOT_A NOT_B NAND NOR XOR XNOR (bit 0 first).
  logic [7:0] v0, v1, v2;
  assign v0 = {outxnor,  outxor,  outnor,  outnand,  notin2,  notin1,  outor,  outand};
  assign v1 = {outxnor1, outxor1, outnor1, outnand1, notin12, notin11, outor1, outand1};
  assign v2 = {outxnor2, outxor2, outnor2, outnand2, notin22, notin21, outor2, outand2};

  // Truth rows indexed by {in1,in2}; columns AND OR NAND NOR XOR XNOR (MSB first).
  bit [5:0] truth [4] = '{6'b001101, 6'b011010, 6'b011010, 6'b110001};

  function automatic logic [7:0] model(input logic r, input logic a, input logic b);
    bit [5:0] row;
    logic [7:0] v;
    if (r) return 8'h00;
    row = truth[{a, b}];
    v = {row[0], row[1], row[2], row[3], ~b, ~a, row[4], row[5]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_banks(input string tag, input logic [7:0] exp);
    check({tag, "_b0"}, v0, exp);
    check({tag, "_b1"}, v1, exp);
    check({tag, "_b2"}, v2, exp);
  endtask

  // Drive inputs mid-cycle, let one edge pass, check just after it.
  task automatic step(input string tag, input logic r, input logic a, input logic b);
    @(negedge clk);
    rst = r; in1 = a; in2 = b;
    @(posedge clk);
    #1;
    check_banks(tag, model(r, a, b));
`ifdef QUES1_MISMATCH_CHK_EN
    check({tag, "_mm"}, {7'b0, mismatch}, 8'h00);
`endif
  endtask

  initial begin
    logic [7:0] held;
    logic ra, rb, rr;

    step("rst1", 1'b1, 1'b1, 1'b1);
    step("rst2", 1'b1, 1'b1, 1'b1);
    step("zero", 1'b0, 1'b0, 1'b0);
    step("sw10", 1'b0, 1'b1, 1'b0);
    step("sw01", 1'b0, 1'b0, 1'b1);
    step("sw11", 1'b0, 1'b1, 1'b1);

    // Glitch in1 between edges: outputs must hold the 11 result.
    held = model(1'b0, 1'b1, 1'b1);
    #2 in1 = 1'b0;
    #2 in1 = 1'b1;
    #1 check_banks("glitch_hold", held);
    in1 = 1'b0;
    #1 check_banks("glitch_pre", held);
    @(posedge clk);
    #1 check_banks("glitch_edge", model(1'b0, 1'b0, 1'b1));

    step("str11a", 1'b0, 1'b1, 1'b1);
    step("str_rst", 1'b1, 1'b1, 1'b1);
    step("str_rel", 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 200; i++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 15) == 0);
      step("rand", rr, ra, rb);
    end

`ifdef QUES1_MISMATCH_CHK_EN
    @(negedge clk);
    rst = 1'b0; in1 = 1'b1; in2 = 1'b0;
    force dut.res2_d = 8'h00;
    @(posedge clk);
    #1 check("mm_not_yet", {7'b0, mismatch}, 8'h00);
    @(negedge clk);
    release dut.res2_d;
    @(posedge clk);
    #1 check("mm_set", {7'b0, mismatch}, 8'h01);
    repeat (3) @(posedge clk);
    #1 check("mm_hold", {7'b0, mismatch}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("mm_clr", {7'b0, mismatch}, 8'h00);
    step("mm_resume", 1'b0, 1'b1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
